// File: rtl/flag_pkg.sv
// Shared constants for the condition-code producer.
// Contents:
//   ALU_*  - ALUOp encodings
//   FLAG_* - bit positions inside the {N,Z,C,V} vector
//   FW_*   - bit positions inside the FlagWrite enable pair
package flag_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/flag_calc.sv
// Raw NZCV computation from the execute-stage ALU outcome (purely combinational).
// Ports:
//   ALUResult - ALU result, WIDTH bits
//   SrcAMsb   - MSB of operand A
//   SrcBMsb   - MSB of operand B, as presented to the ALU before any SUB inversion
//   CarryOut  - adder carry-out (for SUB this is "no borrow")
//   ALUOp     - operation code, see flag_pkg
//   raw_flags - computed {n,z,c,v}; c/v are meaningless for logic ops
module flag_calc
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             SrcAMsb,
    input  logic             SrcBMsb,
    input  logic             CarryOut,
    input  logic [1:0]       ALUOp,
    output logic [3:0]       raw_flags
);

    logic n_s;
    logic z_s;
    logic v_s;

    assign n_s = ALUResult[WIDTH-1];
    assign z_s = (ALUResult == {WIDTH{1'b0}});

    // Overflow: ADD overflows when like-signed operands give an unlike-signed
    // result; SUB uses the original B MSB, so the operand-sign test flips.
    always_comb begin
        v_s = 1'b0;
        case (ALUOp)
            ALU_ADD: v_s = (SrcAMsb == SrcBMsb) & (n_s != SrcAMsb);
            ALU_SUB: v_s = (SrcAMsb != SrcBMsb) & (n_s != SrcAMsb);
            ALU_AND: v_s = 1'b0;
            ALU_ORR: v_s = 1'b0;
            default: v_s = 1'b0;
        endcase
    end

    // Pack into the architectural bit order.
    always_comb begin
        raw_flags         = 4'b0000;
        raw_flags[FLAG_N] = n_s;
        raw_flags[FLAG_Z] = z_s;
        raw_flags[FLAG_C] = CarryOut;
        raw_flags[FLAG_V] = v_s;
    end

endmodule

// File: rtl/flag_unit.sv
// Architectural NZCV flags register with a one-entry shadow for exception
// save/restore.
// Ports:
//   clk, reset             - clock; asynchronous active-low reset
//   ALUResult, SrcAMsb,
//   SrcBMsb, CarryOut,
//   ALUOp                  - execute-stage ALU outcome
//   FlagWrite              - [1] update N,Z   [0] update C,V (arith ops only)
//   CondEx                 - instruction passed its condition check
//   Stall                  - freeze both registers
//   SaveFlags              - shadow <= current Flags
//   RestoreFlags           - Flags <= shadow (overrides the ALU update)
//   Flags                  - registered {N,Z,C,V}
//   FlagsNext              - value Flags takes at the next edge (forwarding)
//   SavedFlags             - shadow register
module flag_unit
    import flag_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic             SrcAMsb,
    input  logic             SrcBMsb,
    input  logic             CarryOut,
    input  logic [1:0]       ALUOp,
    input  logic [1:0]       FlagWrite,
    input  logic             CondEx,
    input  logic             Stall,
    input  logic             SaveFlags,
    input  logic             RestoreFlags,
    output logic [3:0]       Flags,
    output logic [3:0]       FlagsNext,
    output logic [3:0]       SavedFlags
);

    logic [3:0] raw_flags_s;
    logic       wr_nz_s;
    logic       wr_cv_s;
    logic [3:0] flags_next_s;
    logic [3:0] saved_next_s;
    logic [3:0] flags_r;
    logic [3:0] saved_r;

    flag_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .ALUResult (ALUResult),
        .SrcAMsb   (SrcAMsb),
        .SrcBMsb   (SrcBMsb),
        .CarryOut  (CarryOut),
        .ALUOp     (ALUOp),
        .raw_flags (raw_flags_s)
    );

    // ALUOp[1] set means a logic op, which never touches C and V.
    assign wr_nz_s = FlagWrite[FW_NZ] & CondEx & ~Stall;
    assign wr_cv_s = FlagWrite[FW_CV] & CondEx & ~Stall & ~ALUOp[1];

    // Next flags: stall holds, restore wins over the ALU, else per-field merge.
    always_comb begin
        flags_next_s = flags_r;
        if (Stall) begin
            flags_next_s = flags_r;
        end else if (RestoreFlags) begin
            flags_next_s = saved_r;
        end else begin
            if (wr_nz_s) begin
                flags_next_s[FLAG_N] = raw_flags_s[FLAG_N];
                flags_next_s[FLAG_Z] = raw_flags_s[FLAG_Z];
            end else begin
                flags_next_s[FLAG_N] = flags_r[FLAG_N];
                flags_next_s[FLAG_Z] = flags_r[FLAG_Z];
            end
            if (wr_cv_s) begin
                flags_next_s[FLAG_C] = raw_flags_s[FLAG_C];
                flags_next_s[FLAG_V] = raw_flags_s[FLAG_V];
            end else begin
                flags_next_s[FLAG_C] = flags_r[FLAG_C];
                flags_next_s[FLAG_V] = flags_r[FLAG_V];
            end
        end
    end

    // Next shadow: always captures the pre-edge Flags, which makes
    // save+restore a swap and save+update keep the old value.
    always_comb begin
        saved_next_s = saved_r;
        if (SaveFlags && !Stall) begin
            saved_next_s = flags_r;
        end else begin
            saved_next_s = saved_r;
        end
    end

    // Architectural flags register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flags_next_s;
        end
    end

    // Shadow register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            saved_r <= 4'b0000;
        end else begin
            saved_r <= saved_next_s;
        end
    end

    assign Flags      = flags_r;
    assign SavedFlags = saved_r;
    assign FlagsNext  = flags_next_s;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized
// transactions checked against an arithmetic reference model.
module tb_flag_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  ALUResult;
    logic          SrcAMsb;
    logic          SrcBMsb;
    logic          CarryOut;
    logic [1:0]    ALUOp;
    logic [1:0]    FlagWrite;
    logic          CondEx;
    logic          Stall;
    logic          SaveFlags;
    logic          RestoreFlags;
    logic [3:0]    Flags;
    logic [3:0]    FlagsNext;
    logic [3:0]    SavedFlags;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: architectural flags and shadow as separate N,Z,C,V bits.
    logic m_n, m_z, m_c, m_v;
    logic [3:0] m_saved;

    flag_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUResult    (ALUResult),
        .SrcAMsb      (SrcAMsb),
        .SrcBMsb      (SrcBMsb),
        .CarryOut     (CarryOut),
        .ALUOp        (ALUOp),
        .FlagWrite    (FlagWrite),
        .CondEx       (CondEx),
        .Stall        (Stall),
        .SaveFlags    (SaveFlags),
        .RestoreFlags (RestoreFlags),
        .Flags        (Flags),
        .FlagsNext    (FlagsNext),
        .SavedFlags   (SavedFlags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // One instruction: operands a,b are run through real two's-complement
    // arithmetic to get result, carry and signed overflow, then the model
    // applies the update rules. Entered and left at posedge+1.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [1:0] fw, input logic cx,
                         input logic st, input logic sv, input logic rs);
        logic [32:0] wide;
        logic [31:0] res;
        logic        carry;
        logic        ovf;
        longint      sres;
        logic        arith;
        logic [3:0]  old_flags;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_saved;
        carry = 1'b0;
        ovf   = 1'b0;
        arith = 1'b1;
        case (op)
            2'b00: begin
                wide  = {1'b0, a} + {1'b0, b};
                res   = wide[31:0];
                carry = wide[32];
                sres  = longint'($signed(a)) + longint'($signed(b));
                ovf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            2'b01: begin
                res   = a - b;
                carry = (a >= b);
                sres  = longint'($signed(a)) - longint'($signed(b));
                ovf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            end
            2'b10: begin
                res   = a & b;
                carry = 1'($urandom_range(1, 0));
                arith = 1'b0;
            end
            default: begin
                res   = a | b;
                carry = 1'($urandom_range(1, 0));
                arith = 1'b0;
            end
        endcase

        old_flags = {m_n, m_z, m_c, m_v};
        exp_flags = old_flags;
        exp_saved = m_saved;
        if (!st) begin
            if (rs) begin
                exp_flags = m_saved;
            end else begin
                if (fw[1] && cx) begin
                    exp_flags[3] = res[31];
                    exp_flags[2] = (res == 32'd0);
                end
                if (fw[0] && cx && arith) begin
                    exp_flags[1] = carry;
                    exp_flags[0] = ovf;
                end
            end
            if (sv) exp_saved = old_flags;
        end

        ALUResult    = res;
        SrcAMsb      = a[31];
        SrcBMsb      = b[31];
        CarryOut     = carry;
        ALUOp        = op;
        FlagWrite    = fw;
        CondEx       = cx;
        Stall        = st;
        SaveFlags    = sv;
        RestoreFlags = rs;
        #3;
        check({tag, ".next"}, FlagsNext, exp_flags);
        @(posedge clk);
        #1;
        check({tag, ".flags"}, Flags, exp_flags);
        check({tag, ".saved"}, SavedFlags, exp_saved);
        {m_n, m_z, m_c, m_v} = exp_flags;
        m_saved = exp_saved;
    endtask

    initial begin
        reset = 1'b0;
        ALUResult = '0; SrcAMsb = 1'b0; SrcBMsb = 1'b0; CarryOut = 1'b0;
        ALUOp = 2'b00; FlagWrite = 2'b00; CondEx = 1'b0; Stall = 1'b0;
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_saved = 4'b0000;
        #2;
        check("rst.flags", Flags, 4'b0000);
        check("rst.saved", SavedFlags, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b1;

        // ADD overflow: 0x40000000 + 0x40000000 = 0x80000000
        apply("add_ovf", 32'h4000_0000, 32'h4000_0000, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("add_ovf.const", Flags, 4'b1001);
        // SUB equal: 5 - 5
        apply("sub_eq", 32'd5, 32'd5, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("sub_eq.const", Flags, 4'b0110);
        // Gating by CondEx, then by Stall
        apply("gate_cx", 32'h4000_0000, 32'h4000_0000, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        check("gate_cx.const", Flags, 4'b0110);
        apply("gate_st", 32'h4000_0000, 32'h4000_0000, 2'b00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        check("gate_st.const", Flags, 4'b0110);
        // Build 1011: ADD min+min -> 0111, then NZ-only with negative result
        apply("mk0111", 32'h8000_0000, 32'h8000_0000, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("mk1011", 32'h8000_0000, 32'h0000_0000, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mk1011.const", Flags, 4'b1011);
        // AND with zero result, FlagWrite=11: C,V kept
        apply("logic_and", 32'h0000_00F0, 32'h0000_000F, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("logic_and.const", Flags, 4'b0111);
        // Flags 0110, then save together with an ADD overflow update
        apply("pre_sub", 32'd9, 32'd9, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("save_upd", 32'h4000_0000, 32'h4000_0000, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        check("save_upd.flags_c", Flags, 4'b1001);
        check("save_upd.saved_c", SavedFlags, 4'b0110);
        // Swap with a pending ALU update that must be dropped
        apply("swap", 32'd1, 32'd1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
        check("swap.flags_c", Flags, 4'b0110);
        check("swap.saved_c", SavedFlags, 4'b1001);
        apply("restore", 32'd1, 32'd2, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        check("restore.const", Flags, 4'b1001);

        // Randomized transactions
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(5, 0))
                0: b = a;
                1: b = 32'd0 - a;
                2: a = {1'b0, a[30:0]};
                default: ;
            endcase
            apply("rnd", a, b, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                  ($urandom_range(3, 0) != 0), ($urandom_range(7, 0) == 0),
                  ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0));
        end

        // Mid-cycle asynchronous reset with nonzero flags and shadow
        apply("pre_rst0", 32'd3, 32'd3, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("pre_rst1", 32'h4000_0000, 32'h4000_0000, 2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
        ALUOp = 2'b00; FlagWrite = 2'b11; CondEx = 1'b1; Stall = 1'b0;
        SaveFlags = 1'b1; RestoreFlags = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst.flags", Flags, 4'b0000);
        check("async_rst.saved", SavedFlags, 4'b0000);
        @(posedge clk); #1;
        check("rst_hold.flags", Flags, 4'b0000);
        check("rst_hold.saved", SavedFlags, 4'b0000);
        reset = 1'b1;
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_saved = 4'b0000;
        apply("post_rst", 32'h8000_0000, 32'h8000_0000, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_rst.const", Flags, 4'b0111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Producer end of the condition-code interface: computes NZCV from the execute-stage ALU outcome and holds the architectural flags register.
- Its Flags output is the {N,Z,C,V} vector the condition checker consumes one instruction later.
- Gates updates by FlagWrite, CondEx and pipeline stall.
- Provides a one-entry shadow register for flag save/restore on exception entry/return.

Parameters:
- WIDTH, 32, data-path width of ALUResult.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- ALUResult  input  WIDTH  execute-stage ALU result
- SrcAMsb  input  1  MSB of ALU operand A
- SrcBMsb  input  1  MSB of ALU operand B (original, not inverted for SUB)
- CarryOut  input  1  adder carry-out (SUB: carry = no borrow)
- ALUOp  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagWrite  input  2  bit1 = update N,Z; bit0 = update C,V
- CondEx  input  1  instruction passed its condition check
- Stall  input  1  freeze all register updates
- SaveFlags  input  1  copy Flags into shadow register
- RestoreFlags  input  1  load Flags from shadow register
- Flags  output  4  registered {N,Z,C,V}
- FlagsNext  output  4  combinational value Flags takes at next edge (forwarding)
- SavedFlags  output  4  shadow register

Behaviour:
- Reset (reset==0, asynchronous): Flags=4'b0000, SavedFlags=4'b0000. Deassertion takes effect at the next rising edge. Reset mid-operation discards any pending update.
- Flag computation (combinational):
  - n = ALUResult[WIDTH-1]
  - z = (ALUResult == 0), full-width compare
  - c = CarryOut
  - ADD: v = (SrcAMsb == SrcBMsb) & (n != SrcAMsb)
  - SUB: v = (SrcAMsb != SrcBMsb) & (n != SrcAMsb)
- Logic ops (AND/ORR): C and V are never written, even with FlagWrite[0]=1; N and Z follow FlagWrite[1].
- Effective enables:
  - wrNZ = FlagWrite[1] & CondEx & ~Stall
  - wrCV = FlagWrite[0] & CondEx & ~Stall & ~ALUOp[1]
- Update priority per edge (Stall==1 blocks every case; all state holds):
  - RestoreFlags=1 → Flags <= SavedFlags; the ALU update is dropped.
  - Otherwise, fields with an active enable take their computed value; the others hold.
  - SaveFlags=1 → SavedFlags <= current (pre-edge) Flags.
  - Save and Restore together → swap: Flags <= old SavedFlags, SavedFlags <= old Flags.
  - Save together with an ALU update → shadow captures the old value; Flags takes the new one.
- FlagsNext equals exactly what Flags will hold after the next edge, reset excepted. It is purely combinational from the inputs and current state.
- Latency: update visible on Flags one cycle after the instruction; visible on FlagsNext in the same cycle.
- No X propagation: ALUOp is fully decoded, so there is no default-x path.

Decomposition:
- flag_pkg:
  - ALUOp localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - FlagWrite bit indices (FW_NZ=1, FW_CV=0)
- Sub-module flag_calc (combinational): ALUResult, operand MSBs, CarryOut, ALUOp → raw {n,z,c,v}.
- flag_unit: enables, priority mux, two registers.

Test Plan:
- Reset: reset=0 mid-cycle with Flags=1111 → Flags=0000 and SavedFlags=0000 immediately, without waiting for a clock edge.
- ADD overflow: ALUResult=0x80000000, SrcAMsb=0, SrcBMsb=0, CarryOut=0, ALUOp=00, FlagWrite=11, CondEx=1 → FlagsNext=1001 same cycle; Flags=1001 after edge.
- SUB equal: 5-5, ALUResult=0, CarryOut=1, MSBs 0/0, ALUOp=01, FlagWrite=11 → Flags=0110.
- Gating: from Flags=0110, FlagWrite=11 with CondEx=0 → Flags stays 0110. Repeat with CondEx=1, Stall=1 → stays 0110.
- Logic op: from Flags=1011, ALUOp=10, ALUResult=0, FlagWrite=11 → Flags=0111 (C,V kept).
- Save/restore swap: Flags=1001, SavedFlags=0110, Save=Restore=1, FlagWrite=11 → Flags=0110, SavedFlags=1001. Next cycle Restore only → Flags=1001.
